// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control inputs and PC/status outputs of the fetch unit.
interface fetch_unit_if;
   logic        Start;
   logic [9:0]  StartAddr;
   logic        Hold;
   logic        Ack;
   logic        Jump;
   logic        BranchEn;
   logic        BOLEn;
   logic        Cond;
   logic [9:0]  Target;
   logic [7:0]  Offset;
   logic [9:0]  ProgCtr;
   logic        Busy;
   logic        Done;
   logic [15:0] CycleCnt;
   modport master (
      output Start, StartAddr, Hold, Ack, Jump, BranchEn, BOLEn, Cond, Target, Offset,
      input  ProgCtr, Busy, Done, CycleCnt
   );
   modport slave (
      input  Start, StartAddr, Hold, Ack, Jump, BranchEn, BOLEn, Cond, Target, Offset,
      output ProgCtr, Busy, Done, CycleCnt
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/RUN/DONE program counter sequencer with jump and branch redirects.
// Define FETCH_CYCLE_CNT_EN to build the saturating executed-cycle counter.
module fetch_unit (
   input  logic         Clk,
   input  logic         Reset,
   fetch_unit_if.slave  f
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t     state_q, state_d;
   logic [9:0] pc_q, pc_d;
   logic       launch;
   assign launch = (state_q == IDLE || state_q == DONE) && f.Start;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE, DONE: begin
            if (f.Start) begin
               state_d = RUN;
               pc_d    = f.StartAddr;
            end
         end
         RUN: begin
            if (f.Ack)
               state_d = DONE;
            else if (f.Hold)
               pc_d = pc_q;
            else if (f.Jump)
               pc_d = f.Target;
            else if (f.BranchEn && f.Cond)
               pc_d = f.BOLEn ? pc_q + {{2{f.Offset[7]}}, f.Offset} : f.Target;
            else
               pc_d = pc_q + 10'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end
   assign f.ProgCtr = pc_q;
   assign f.Busy    = (state_q == RUN);
   assign f.Done    = (state_q == DONE);
`ifdef FETCH_CYCLE_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = launch ? 16'd0
            : (state_q == RUN && cnt_q != 16'hFFFF) ? cnt_q + 16'd1
            : cnt_q;
   end
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
   assign f.CycleCnt = cnt_q;
`else
   logic unused_launch;
   assign unused_launch = launch;
   assign f.CycleCnt    = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of PC sequencing, redirect priority, wrap and reset.
module tb_fetch_unit;
   logic Clk, Reset;
   int total = 0;
   int bad = 0;
   fetch_unit_if f ();
   fetch_unit dut (.Clk(Clk), .Reset(Reset), .f(f.slave));
   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // c is the counter value expected when the counter is built; otherwise it reads 0
   task automatic chk(input string tag, input logic [9:0] pc, input logic b, input logic d, input logic [15:0] c);
      cmp({tag, ".pc"}, {6'd0, f.ProgCtr}, {6'd0, pc});
      cmp({tag, ".busy"}, {15'd0, f.Busy}, {15'd0, b});
      cmp({tag, ".done"}, {15'd0, f.Done}, {15'd0, d});
`ifdef FETCH_CYCLE_CNT_EN
      cmp({tag, ".cnt"}, f.CycleCnt, c);
`else
      cmp({tag, ".cnt"}, f.CycleCnt, 16'd0);
`endif
   endtask
   task automatic clr();
      f.Start = 0; f.StartAddr = 0; f.Hold = 0; f.Ack = 0; f.Jump = 0;
      f.BranchEn = 0; f.BOLEn = 0; f.Cond = 0; f.Target = 0; f.Offset = 0;
   endtask
   initial begin
      Reset = 0;
      clr();
      #12;
      chk("reset", 10'd0, 0, 0, 16'd0);
      Reset = 1;
      tick();
      chk("idle", 10'd0, 0, 0, 16'd0);
      f.Start = 1; f.StartAddr = 10'd5;
      tick(); chk("launch5", 10'd5, 1, 0, 16'd0);
      clr();
      tick(); chk("seq6", 10'd6, 1, 0, 16'd1);
      tick(); chk("seq7", 10'd7, 1, 0, 16'd2);
      tick(); chk("seq8", 10'd8, 1, 0, 16'd3);
      f.Start = 1; f.StartAddr = 10'd300;
      tick(); chk("start_in_run", 10'd9, 1, 0, 16'd4);
      clr(); f.Jump = 1; f.Target = 10'd10;
      tick(); chk("jump10", 10'd10, 1, 0, 16'd5);
      clr(); f.BranchEn = 1; f.BOLEn = 1; f.Cond = 1; f.Offset = 8'hFC;
      tick(); chk("rel_m4", 10'd6, 1, 0, 16'd6);
      f.Jump = 1; f.Target = 10'd10;
      tick(); chk("jump_over_br", 10'd10, 1, 0, 16'd7);
      f.Jump = 0; f.Cond = 0;
      tick(); chk("br_not_taken", 10'd11, 1, 0, 16'd8);
      clr(); f.BranchEn = 1; f.Cond = 1; f.Target = 10'd1023; f.Offset = 8'h10;
      tick(); chk("abs_br", 10'd1023, 1, 0, 16'd9);
      clr();
      tick(); chk("wrap_inc", 10'd0, 1, 0, 16'd10);
      f.BOLEn = 1; f.Cond = 1; f.Offset = 8'h40; f.Target = 10'd500;
      tick(); chk("bolen_alone", 10'd1, 1, 0, 16'd11);
      clr();
      tick(); chk("seq2", 10'd2, 1, 0, 16'd12);
      f.BranchEn = 1; f.BOLEn = 1; f.Cond = 1; f.Offset = 8'hFD;
      tick(); chk("rel_wrap", 10'd1023, 1, 0, 16'd13);
      clr(); f.Hold = 1; f.Jump = 1; f.Target = 10'd50;
      tick(); chk("hold_jump", 10'd1023, 1, 0, 16'd14);
      f.Ack = 1; f.Target = 10'd100;
      tick(); chk("ack", 10'd1023, 0, 1, 16'd15);
      clr(); f.Jump = 1; f.Target = 10'd200;
      tick(); chk("done_hold", 10'd1023, 0, 1, 16'd15);
      clr(); f.Start = 1; f.StartAddr = 10'd0;
      tick(); chk("relaunch0", 10'd0, 1, 0, 16'd0);
      clr(); f.Jump = 1; f.Target = 10'd37;
      tick(); chk("jump37", 10'd37, 1, 0, 16'd1);
      #3;
      Reset = 0;
      #1;
      chk("async_reset", 10'd0, 0, 0, 16'd0);
      #2;
      Reset = 1;
      tick(); chk("post_reset", 10'd0, 0, 0, 16'd0);
      f.Target = 10'd77;
      tick(); chk("idle_ignore", 10'd0, 0, 0, 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset; low forces reset state immediately, regardless of Clk.
REQ-003 SHALL have port Start  input  1  program launch request, sampled only in IDLE and DONE.
REQ-004 SHALL have port StartAddr  input  10  PC value loaded on launch.
REQ-005 SHALL have port Hold  input  1  freeze PC for the current cycle (stall).
REQ-006 SHALL have port Ack  input  1  decoder halt indication (instruction all ones).
REQ-007 SHALL have port Jump  input  1  unconditional absolute jump to Target.
REQ-008 SHALL have port BranchEn  input  1  conditional branch request.
REQ-009 SHALL have port BOLEn  input  1  qualifies BranchEn: 1 = PC-relative offset, 0 = absolute Target.
REQ-010 SHALL have port Cond  input  1  branch condition flag from the ALU.
REQ-011 SHALL have port Target  input  10  absolute branch/jump address from the branch LUT.
REQ-012 SHALL have port Offset  input  8  signed two's-complement relative displacement.
REQ-013 SHALL have port ProgCtr  output  10  registered PC driving the instruction ROM address.
REQ-014 SHALL have port Busy  output  1  high while in RUN.
REQ-015 SHALL have port Done  output  1  high while in DONE.
REQ-016 SHALL have port CycleCnt  output  16  executed-cycle count (see Configuration).

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, RUN, DONE; Busy = (state==RUN), Done = (state==DONE), both registered-state decodes.
REQ-018 IDLE: Start=1 SHALL load ProgCtr<=StartAddr and go to RUN on the same edge; Start=0 holds state and PC.
REQ-019 RUN: the next PC SHALL be chosen per cycle by strict priority: Ack > Hold > Jump > (BranchEn&Cond) > PC+1.
REQ-020 Ack=1 in RUN SHALL hold ProgCtr and go to DONE on that edge; Hold, Jump, and branch inputs are ignored that cycle.
REQ-021 Hold=1 (no Ack) SHALL keep ProgCtr unchanged and remain in RUN.
REQ-022 Jump=1 SHALL load ProgCtr<=Target.
REQ-023 BranchEn=1, Cond=1, BOLEn=0 SHALL load ProgCtr<=Target; BranchEn=1, Cond=1, BOLEn=1 SHALL load ProgCtr<=ProgCtr+sign_extend(Offset) modulo 1024.
REQ-024 BranchEn=1 with Cond=0 SHALL advance PC+1 (not taken); BOLEn without BranchEn SHALL be ignored.
REQ-025 PC+1 and relative arithmetic SHALL wrap modulo 1024 (1023+1 -> 0; 2+(-3) -> 1023), with no flag raised.
REQ-026 Start in RUN SHALL be ignored; DONE with Start=1 SHALL reload StartAddr and re-enter RUN, else hold with ProgCtr frozen.
REQ-027 Latency: ProgCtr SHALL reflect a redirect on the first rising edge after the decode cycle; no delay slot and no bubble.
REQ-028 Inputs other than Start/StartAddr SHALL be ignored outside RUN.

Reset
REQ-029 Reset low SHALL asynchronously force state=IDLE, ProgCtr=0, CycleCnt=0, Busy=0, Done=0.
REQ-030 Reset asserted mid-RUN SHALL abort the program with no completion indication; after release, the unit waits in IDLE for Start.

Configuration
REQ-031 Macro FETCH_CYCLE_CNT_EN: when defined, CycleCnt SHALL clear on launch (IDLE/DONE -> RUN), increment by 1 on every RUN cycle including Hold and Ack cycles, saturate at 16'hFFFF, and hold in IDLE and DONE.
REQ-032 Without FETCH_CYCLE_CNT_EN, CycleCnt SHALL be tied to 0 and no counter register SHALL be synthesized.

Verification
REQ-033 Reset low mid-RUN at PC=37 -> ProgCtr=0, Busy=0, Done=0 before the next Clk edge.
REQ-034 Start with StartAddr=5, then 3 plain cycles -> ProgCtr sequence 5,6,7,8; Busy=1 throughout.
REQ-035 PC=10: BranchEn=1, BOLEn=1, Cond=1, Offset=8'hFC -> ProgCtr=6; the same inputs with Cond=0 -> ProgCtr=11.
REQ-036 PC=1023, no redirect -> ProgCtr=0; PC=2, relative branch with Offset=-3 -> ProgCtr=1023.
REQ-037 Same cycle Ack=1, Jump=1, Target=100 -> ProgCtr holds, Done=1 next edge; then Start=1, StartAddr=0 -> RUN at PC 0, CycleCnt=0 (macro defined).
REQ-038 Hold=1 and Jump=1, Target=50 in the same cycle -> ProgCtr unchanged; with the macro defined, CycleCnt still increments.
